// File: rtl/fifo_block_writer_pkg.sv
// Shared types and constants for the FIFO block writer.
package fifo_block_writer_pkg;

    typedef enum logic [1:0] {StIdle, StGap, StWrite, StDone} state_e;

    localparam logic MODE_INC  = 1'b0;
    localparam logic MODE_LFSR = 1'b1;

    // Right-shift Galois mask for x^16+x^14+x^13+x^11+1.
    localparam logic [15:0] THROTTLE_TAPS = 16'hB400;

    // Maximal-length Galois masks; bit (e-1) set for each polynomial term x^e.
    function automatic logic [63:0] payload_taps(input int unsigned width);
        case (width)
            8:       return 64'h0000_0000_0000_00B8;
            9:       return 64'h0000_0000_0000_0110;
            10:      return 64'h0000_0000_0000_0240;
            11:      return 64'h0000_0000_0000_0500;
            12:      return 64'h0000_0000_0000_0829;
            16:      return 64'h0000_0000_0000_B400;
            24:      return 64'h0000_0000_00E1_0000;
            32:      return 64'h0000_0000_8020_0003;
            default: return (64'd1 << (width - 1)) | 64'd1;
        endcase
    endfunction

endpackage

// File: rtl/fifo_writer_lfsr.sv
// Right-shift Galois LFSR with parallel load; exposes the low OutW bits of the state.
module fifo_writer_lfsr #(
    parameter int unsigned     Width = 16,
    parameter int unsigned     OutW  = Width,
    parameter logic [Width-1:0] Taps = '0,
    parameter logic [Width-1:0] Seed = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    output logic [OutW-1:0]  value_o
);

    logic [Width-1:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = load_val_i;
        end else if (en_i) begin
            state_d = (state_q >> 1) ^ (state_q[0] ? Taps : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= Seed;
        end else begin
            state_q <= state_d;
        end
    end

    assign value_o = state_q[OutW-1:0];

endmodule

// File: rtl/fifo_block_writer.sv
// Block write traffic source for a FIFO write port with LFSR-throttled idle gaps.
// Optional build macro FIFO_BLOCK_WRITER_CHECKSUM_EN adds an XOR checksum output.
module fifo_block_writer
    import fifo_block_writer_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned LEN_W  = 10,
    parameter int unsigned RATE_W = 10,
    parameter logic [15:0] SEED   = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  length,
    input  logic [RATE_W-1:0] rate,
    input  logic              mode,
    input  logic [WIDTH-1:0]  base,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  count,
    output logic [WIDTH-1:0]  dout,
    output logic              wren,
    input  logic              full
`ifdef FIFO_BLOCK_WRITER_CHECKSUM_EN
    ,
    output logic [WIDTH-1:0]  checksum
`endif
);

    localparam logic [WIDTH-1:0] PAY_TAPS = WIDTH'(payload_taps(WIDTH));

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  len_q, count_q;
    logic [RATE_W-1:0] rate_q, rate_eff, thr_bits;
    logic              mode_q;
    logic [WIDTH-1:0]  payload, pay_load_val;
    logic              start_ok, launch, accept, last, pass;
    logic              thr_step, pay_load, pay_step;

    assign start_ok = (state_q == StIdle) && start;
    assign launch   = start_ok && (length != '0);
    assign accept   = (state_q == StWrite) && !full;
    assign last     = accept && ((count_q + LEN_W'(1)) == len_q);

    // rate=0 would never pass; all-ones must always pass despite the strict compare.
    assign rate_eff = (rate_q == '0) ? RATE_W'(1) : rate_q;
    assign pass     = (&rate_q) || (thr_bits < rate_eff);
    assign thr_step = (state_q == StGap) || (accept && !last);

    assign pay_load     = launch || (accept && (mode_q == MODE_INC));
    assign pay_step     = accept && (mode_q == MODE_LFSR);
    assign pay_load_val = !launch                          ? payload + WIDTH'(1) :
                          (mode == MODE_LFSR && base == '0) ? WIDTH'(1) : base;

    fifo_writer_lfsr #(
        .Width (16),
        .OutW  (RATE_W),
        .Taps  (THROTTLE_TAPS),
        .Seed  (SEED)
    ) u_throttle (
        .clk        (clk),
        .rst        (rst),
        .en_i       (thr_step),
        .load_i     (1'b0),
        .load_val_i (16'h0000),
        .value_o    (thr_bits)
    );

    fifo_writer_lfsr #(
        .Width (WIDTH),
        .OutW  (WIDTH),
        .Taps  (PAY_TAPS),
        .Seed  ('0)
    ) u_payload (
        .clk        (clk),
        .rst        (rst),
        .en_i       (pay_step),
        .load_i     (pay_load),
        .load_val_i (pay_load_val),
        .value_o    (payload)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (length == '0) ? StDone : StGap;
                end
            end
            StGap: begin
                if (pass) begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (last) begin
                    state_d = StDone;
                end else if (accept && !pass) begin
                    state_d = StGap;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            len_q   <= '0;
            rate_q  <= '0;
            mode_q  <= MODE_INC;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                count_q <= '0;
            end else if (accept) begin
                count_q <= count_q + LEN_W'(1);
            end
            if (launch) begin
                len_q  <= length;
                rate_q <= rate;
                mode_q <= mode;
            end
        end
    end

`ifdef FIFO_BLOCK_WRITER_CHECKSUM_EN
    logic [WIDTH-1:0] checksum_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            checksum_q <= '0;
        end else if (start_ok) begin
            checksum_q <= '0;
        end else if (accept) begin
            checksum_q <= checksum_q ^ payload;
        end
    end

    assign checksum = checksum_q;
`endif

    assign busy  = (state_q == StGap) || (state_q == StWrite);
    assign done  = (state_q == StDone);
    assign wren  = (state_q == StWrite);
    assign dout  = payload;
    assign count = count_q;

endmodule
